// File: rtl/sd_sector_writer.sv
// sd_sector_writer: arms on a start pulse, gates frame capture into the SD FIFO
// and writes one frame as a run of single-sector writes at incrementing
// addresses, checking the controller's busy/word handshake on every sector.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | waiting for start after reset
// WAIT_INIT   | armed, waiting for SD card initialisation
// WAIT_DATA   | capture enabled, waiting for one sector of data in the FIFO
// START       | wr_start_en pulse to the controller
// WAIT_BUSY_H | waiting for controller busy to rise (timed)
// WAIT_BUSY_L | counting word requests until busy falls
// NEXT        | sector accepted, advance address and sector count
// DONE        | whole frame written, waiting for re-arm
// ERR         | timeout or bad word count, waiting for re-arm
`timescale 1ns/1ps
module sd_sector_writer #(
  parameter int unsigned START_SEC      = 20000,
  parameter int unsigned SECS_PER_FRAME = 3072,
  parameter int unsigned WORDS_PER_SEC  = 256,
  parameter int unsigned USEDW_W        = 10,
  parameter int unsigned TIMEOUT_CYC    = 1000000
) (
  input  logic               clk_ref,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sd_init_done,
  input  logic [USEDW_W-1:0] fifo_rdusedw,
  input  logic               wr_busy,
  input  logic               wr_req,
  output logic               wr_start_en,
  output logic [31:0]        wr_sec_addr,
  output logic               cap_en,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        sec_cnt
);

  // Two spare bits so an over-long sector is still distinguishable from a good one.
  localparam int CNT_W = $clog2(WORDS_PER_SEC) + 2;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] WORDS_EXACT = CNT_W'(WORDS_PER_SEC);
  localparam logic [15:0]      SECS_LAST   = 16'(SECS_PER_FRAME);
  localparam logic [31:0]      ADDR_FIRST  = 32'(START_SEC);

  typedef enum logic [3:0] {
    IDLE,
    WAIT_INIT,
    WAIT_DATA,
    START,
    WAIT_BUSY_H,
    WAIT_BUSY_L,
    NEXT,
    DONE,
    ERR
  } state_t;

  state_t             state;
  logic               wr_busy_d;
  logic [TMR_W-1:0]   timer;
  logic [CNT_W-1:0]   req_cnt;

  logic               busy_fall;
  logic               thr_hit;
  logic [TMR_W-1:0]   timer_inc;
  logic [CNT_W-1:0]   req_inc;
  logic [15:0]        sec_inc;

  // Next-value helpers; a request coinciding with the busy falling edge is
  // folded into req_inc so it is counted before the word-count comparison.
  always_comb begin
    busy_fall = wr_busy_d & ~wr_busy;
    thr_hit   = 32'(fifo_rdusedw) >= WORDS_PER_SEC;
    timer_inc = timer + TMR_W'(1);
    req_inc   = (wr_req && (req_cnt != '1)) ? req_cnt + CNT_W'(1) : req_cnt;
    sec_inc   = sec_cnt + 16'd1;
  end

  // One-cycle delayed busy for edge detection; resets low so no falling edge
  // is seen right after reset.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) wr_busy_d <= 1'b0;
    else        wr_busy_d <= wr_busy;
  end

  // Sector-write sequencer with registered outputs.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_start_en <= 1'b0;
      wr_sec_addr <= ADDR_FIRST;
      cap_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      sec_cnt     <= '0;
      timer       <= '0;
      req_cnt     <= '0;
    end else begin
      wr_start_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state       <= WAIT_INIT;
            wr_sec_addr <= ADDR_FIRST;
            sec_cnt     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b1;
          end
        end
        WAIT_INIT: begin
          if (sd_init_done) begin
            state  <= WAIT_DATA;
            cap_en <= 1'b1;
          end
        end
        WAIT_DATA: begin
          if (thr_hit) begin
            state       <= START;
            wr_start_en <= 1'b1;
          end
        end
        START: begin
          timer   <= '0;
          req_cnt <= '0;
          state   <= WAIT_BUSY_H;
        end
        WAIT_BUSY_H: begin
          if (wr_busy) begin
            state <= WAIT_BUSY_L;
          end else if (timer_inc == TMR_LAST) begin
            state  <= ERR;
            err    <= 1'b1;
            cap_en <= 1'b0;
            busy   <= 1'b0;
          end else begin
            timer <= timer_inc;
          end
        end
        WAIT_BUSY_L: begin
          req_cnt <= req_inc;
          if (busy_fall) begin
            if (req_inc == WORDS_EXACT) begin
              state <= NEXT;
            end else begin
              state  <= ERR;
              err    <= 1'b1;
              cap_en <= 1'b0;
              busy   <= 1'b0;
            end
          end
        end
        NEXT: begin
          sec_cnt     <= sec_inc;
          wr_sec_addr <= wr_sec_addr + 32'd1;
          if (sec_inc == SECS_LAST) begin
            state  <= DONE;
            done   <= 1'b1;
            cap_en <= 1'b0;
            busy   <= 1'b0;
          end else begin
            state <= WAIT_DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_writer.sv
// Bench for sd_sector_writer: a scoreboard of expected sector addresses is
// filled as sectors are set up and drained by a monitor on wr_start_en.
`timescale 1ns/1ps
module tb_sd_sector_writer;

  localparam int unsigned START_SEC = 20000;
  localparam int unsigned SPF       = 2;
  localparam int unsigned WPS       = 256;
  localparam int unsigned UW        = 10;
  localparam int unsigned TO        = 16;

  logic          clk_ref      = 1'b0;
  logic          rst_n        = 1'b0;
  logic          start        = 1'b0;
  logic          sd_init_done = 1'b0;
  logic [UW-1:0] fifo_rdusedw = '0;
  logic          wr_busy      = 1'b0;
  logic          wr_req       = 1'b0;
  logic          wr_start_en;
  logic [31:0]   wr_sec_addr;
  logic          cap_en;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   sec_cnt;

  int          n_chk = 0;
  int          n_err = 0;
  int          starts_seen = 0;
  logic        prev_start = 1'b0;
  logic [31:0] exp_addr[$];

  sd_sector_writer #(
    .START_SEC     (START_SEC),
    .SECS_PER_FRAME(SPF),
    .WORDS_PER_SEC (WPS),
    .USEDW_W       (UW),
    .TIMEOUT_CYC   (TO)
  ) dut (
    .clk_ref     (clk_ref),
    .rst_n       (rst_n),
    .start       (start),
    .sd_init_done(sd_init_done),
    .fifo_rdusedw(fifo_rdusedw),
    .wr_busy     (wr_busy),
    .wr_req      (wr_req),
    .wr_start_en (wr_start_en),
    .wr_sec_addr (wr_sec_addr),
    .cap_en      (cap_en),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .sec_cnt     (sec_cnt)
  );

  always #5 clk_ref = ~clk_ref;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_ref);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr_start_en"}, wr_start_en, 0);
    chk({tag, "_addr"}, wr_sec_addr, START_SEC);
    chk({tag, "_cap_en"}, cap_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_sec_cnt"}, sec_cnt, 0);
  endtask

  task automatic wait_start(output bit seen);
    int t;
    t = 0;
    while (wr_start_en !== 1'b1 && t < 100) begin
      tick(1);
      t++;
    end
    seen = (wr_start_en === 1'b1);
    chk("start_arrived", seen, 1);
  endtask

  // Controller model: busy rises after the request, nreq word requests, then
  // busy drops with wr_req = extra in the same cycle. poke pulses start mid-sector.
  task automatic serve(input int nreq, input bit extra, input bit poke);
    bit seen;
    wait_start(seen);
    if (!seen) return;
    tick(1);
    wr_busy = 1'b1;
    for (int i = 0; i < nreq; i++) begin
      tick(1);
      wr_req = 1'b1;
      start  = poke && (i == 100);
    end
    tick(1);
    wr_req  = extra;
    wr_busy = 1'b0;
    start   = 1'b0;
    tick(1);
    wr_req = 1'b0;
  endtask

  // Scoreboard monitor: each wr_start_en must be a single-cycle pulse and
  // must match the next expected sector address.
  always @(negedge clk_ref) begin
    if (wr_start_en === 1'b1) begin
      starts_seen++;
      chk("start_width", prev_start, 0);
      if (exp_addr.size() == 0) chk("start_expected", exp_addr.size(), 1);
      else chk("sec_addr", wr_sec_addr, exp_addr.pop_front());
    end
    prev_start <= wr_start_en;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    bit seen;
    int k;

    tick(2);
    chk_reset("rst");
    rst_n = 1'b1;
    tick(1);

    // Normal frame with the data-threshold check in the first sector.
    pulse_start();
    chk("arm_busy", busy, 1);
    chk("arm_cap_en", cap_en, 0);
    tick(3);
    chk("wait_init_cap_en", cap_en, 0);
    sd_init_done = 1'b1;
    tick(1);
    chk("cap_en_on", cap_en, 1);
    fifo_rdusedw = 10'd255;
    tick(50);
    chk("no_start_255", starts_seen, 0);
    exp_addr.push_back(START_SEC);
    fifo_rdusedw = 10'd256;
    tick(1);
    chk("thr_latency", wr_start_en, 1);
    serve(256, 1'b0, 1'b0);
    exp_addr.push_back(START_SEC + 1);
    tick(1);
    chk("sec_cnt_1", sec_cnt, 1);
    serve(256, 1'b0, 1'b1);
    tick(4);
    chk("frame_done", done, 1);
    chk("frame_sec_cnt", sec_cnt, 2);
    chk("frame_cap_en", cap_en, 0);
    chk("frame_busy", busy, 0);
    chk("frame_err", err, 0);
    chk("frame_starts", starts_seen, 2);
    chk("frame_addr_end", wr_sec_addr, START_SEC + 2);

    // Re-arm from DONE, then a short sector (255 words).
    exp_addr.push_back(START_SEC);
    pulse_start();
    chk("rearm_done", done, 0);
    chk("rearm_sec_cnt", sec_cnt, 0);
    chk("rearm_addr", wr_sec_addr, START_SEC);
    chk("rearm_busy", busy, 1);
    serve(255, 1'b0, 1'b0);
    tick(3);
    chk("short_err", err, 1);
    chk("short_sec_cnt", sec_cnt, 0);
    chk("short_cap_en", cap_en, 0);
    chk("short_busy", busy, 0);
    chk("short_addr", wr_sec_addr, START_SEC);

    // Long sector: 256 words plus one in the falling-edge cycle.
    exp_addr.push_back(START_SEC);
    pulse_start();
    chk("rearm_err_clr", err, 0);
    serve(256, 1'b1, 1'b0);
    tick(3);
    chk("long_err", err, 1);
    chk("long_sec_cnt", sec_cnt, 0);

    // Busy never rises: err exactly TO cycles after the request pulse.
    exp_addr.push_back(START_SEC);
    pulse_start();
    wait_start(seen);
    k = 0;
    while (err !== 1'b1 && k < 40) begin
      tick(1);
      k++;
    end
    chk("timeout_cycles", k, TO);
    chk("timeout_cap_en", cap_en, 0);
    chk("timeout_addr", wr_sec_addr, START_SEC);
    chk("timeout_busy", busy, 0);

    // Reset in the middle of a sector, then a stale busy falling edge.
    exp_addr.push_back(START_SEC);
    pulse_start();
    wait_start(seen);
    tick(1);
    wr_busy = 1'b1;
    repeat (10) begin
      tick(1);
      wr_req = 1'b1;
    end
    tick(1);
    wr_req = 1'b0;
    tick(2);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    tick(1);
    chk_reset("midrst");
    rst_n = 1'b1;
    tick(1);
    wr_busy = 1'b0;
    tick(5);
    chk_reset("stale");

    chk("sb_drained", exp_addr.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
